// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD constants, step encoding and helpers for the up/down counter.
// Imported by the digit cell and the counter top.
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;
   localparam int BCD_MAX_DIGITS = 6;
   localparam int BCD_FULL_W = BCD_MAX_DIGITS * BCD_DIGIT_W;

   typedef enum logic [1:0] {
      STEP_HOLD = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DOWN = 2'd2
   } step_e;

   // Widest packed BCD image of a decimal value; callers slice to their digit count.
   function automatic logic [BCD_FULL_W-1:0] dec_to_bcd(input int value);
      logic [BCD_FULL_W-1:0] bcd;
      int remaining;
      bcd = '0;
      remaining = value;
      for (int k = 0; k < BCD_MAX_DIGITS; k++) begin
         bcd[BCD_DIGIT_W*k +: BCD_DIGIT_W] = BCD_DIGIT_W'(remaining % 10);
         remaining = remaining / 10;
      end
      return bcd;
   endfunction

   function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] digit);
      return digit <= BCD_NINE;
   endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle of the BCD up/down counter. The counter is the slave;
// whatever sequences it (or the previous cascade stage) is the master.
interface bcd_updown_counter_if #(
   parameter int DIGITS    = 2,
   parameter int MAX_COUNT = 99,
   parameter int BIN_W     = $clog2(MAX_COUNT + 1)
);

   logic                  clear_i;
   logic                  load_i;
   logic [4*DIGITS-1:0]   load_bcd_i;
   logic                  inc_i;
   logic                  dec_i;
   logic [4*DIGITS-1:0]   count_bcd_o;
   logic [BIN_W-1:0]      count_bin_o;
   logic                  carry_o;
   logic                  borrow_o;
   logic                  load_err_o;

   modport master (
      output clear_i, load_i, load_bcd_i, inc_i, dec_i,
      input  count_bcd_o, count_bin_o, carry_o, borrow_o, load_err_o
   );

   modport slave (
      input  clear_i, load_i, load_bcd_i, inc_i, dec_i,
      output count_bcd_o, count_bin_o, carry_o, borrow_o, load_err_o
   );

endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One BCD decade: clear/load/step with ripple carry (9->0) and borrow (0->9).
// inc_i and dec_i are never asserted together by the counter top.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic                   load_i,
   input  logic [BCD_DIGIT_W-1:0] load_val_i,
   input  logic                   inc_i,
   input  logic                   dec_i,
   output logic [BCD_DIGIT_W-1:0] digit_o,
   output logic                   carry_o,
   output logic                   borrow_o
);

   logic [BCD_DIGIT_W-1:0] digit_q;
   logic [BCD_DIGIT_W-1:0] digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clear_i) begin
         digit_d = '0;
      end else if (load_i) begin
         digit_d = load_val_i;
      end else if (inc_i) begin
         digit_d = (digit_q == BCD_NINE) ? '0 : digit_q + 4'd1;
      end else if (dec_i) begin
         digit_d = (digit_q == '0) ? BCD_NINE : digit_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o  = digit_q;
   assign carry_o  = inc_i & (digit_q == BCD_NINE);
   assign borrow_o = dec_i & (digit_q == '0);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with binary shadow, load checking and cascade pulses.
// Define BCD_CNT_SATURATE_EN to hold at the range ends instead of wrapping.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS    = 2,
   parameter int MAX_COUNT = 99,
   parameter int BIN_W     = $clog2(MAX_COUNT + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   bcd_updown_counter_if.slave  bus
);

   localparam int BCD_W = DIGITS * BCD_DIGIT_W;
   localparam logic [BCD_FULL_W-1:0] MAX_BCD_FULL = dec_to_bcd(MAX_COUNT);
   localparam logic [BCD_W-1:0] MAX_BCD = MAX_BCD_FULL[BCD_W-1:0];
   localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_COUNT);

   wire  [BCD_W-1:0]  countBcd;
   wire  [DIGITS:0]   incChain;
   wire  [DIGITS:0]   decChain;
   logic              unusedRipple;

   step_e             stepOp;
   logic              atMax;
   logic              atZero;
   logic              loadValid;
   int                loadValue;
   logic              stepUp;
   logic              stepDown;
   logic              wrapUp;
   logic              wrapDown;
   logic              digitClear;
   logic              digitLoad;
   logic [BCD_W-1:0]  digitLoadVal;

   logic [BIN_W-1:0]  countBin_q;
   logic [BIN_W-1:0]  countBin_d;
   logic              loadErr_q;
   logic              loadErr_d;

   assign atMax  = (countBcd == MAX_BCD);
   assign atZero = (countBcd == '0);

   always_comb begin
      stepOp = STEP_HOLD;
      if (!bus.clear_i && !bus.load_i) begin
         if (bus.inc_i && !bus.dec_i) begin
            stepOp = STEP_UP;
         end else if (bus.dec_i && !bus.inc_i) begin
            stepOp = STEP_DOWN;
         end
      end
   end

   // Most significant digit first so the running value is plain decimal accumulation.
   always_comb begin
      loadValid = 1'b1;
      loadValue = 0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (!bcd_digit_valid(bus.load_bcd_i[BCD_DIGIT_W*k +: BCD_DIGIT_W])) begin
            loadValid = 1'b0;
         end
         loadValue = loadValue * 10 + int'(bus.load_bcd_i[BCD_DIGIT_W*k +: BCD_DIGIT_W]);
      end
      if (loadValue > MAX_COUNT) begin
         loadValid = 1'b0;
      end
   end

   assign stepUp   = (stepOp == STEP_UP) && !atMax;
   assign stepDown = (stepOp == STEP_DOWN) && !atZero;

`ifdef BCD_CNT_SATURATE_EN
   assign wrapUp   = 1'b0;
   assign wrapDown = 1'b0;
`else
   assign wrapUp   = (stepOp == STEP_UP) && atMax;
   assign wrapDown = (stepOp == STEP_DOWN) && atZero;
`endif

   // Range-end wraps reuse the digits' clear and load paths, so a truncated
   // MAX_COUNT never lets the ripple chain reach unused upper codes.
   assign digitClear   = bus.clear_i | wrapUp;
   assign digitLoad    = (bus.load_i & loadValid) | wrapDown;
   assign digitLoadVal = wrapDown ? MAX_BCD : bus.load_bcd_i;

   assign incChain[0] = stepUp;
   assign decChain[0] = stepDown;

   genvar g;
   for (g = 0; g < DIGITS; g++) begin : gDigit
      bcd_digit uDigit (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .clear_i    (digitClear),
         .load_i     (digitLoad),
         .load_val_i (digitLoadVal[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
         .inc_i      (incChain[g]),
         .dec_i      (decChain[g]),
         .digit_o    (countBcd[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
         .carry_o    (incChain[g+1]),
         .borrow_o   (decChain[g+1])
      );
   end

   assign unusedRipple = incChain[DIGITS] ^ decChain[DIGITS];

   // Binary shadow follows exactly the same decision tree as the BCD digits.
   always_comb begin
      countBin_d = countBin_q;
      if (digitClear) begin
         countBin_d = '0;
      end else if (digitLoad) begin
         countBin_d = wrapDown ? MAX_BIN : BIN_W'(loadValue);
      end else if (stepUp) begin
         countBin_d = countBin_q + BIN_W'(1);
      end else if (stepDown) begin
         countBin_d = countBin_q - BIN_W'(1);
      end
   end

   assign loadErr_d = !bus.clear_i && bus.load_i && !loadValid;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         countBin_q <= '0;
         loadErr_q  <= 1'b0;
      end else begin
         countBin_q <= countBin_d;
         loadErr_q  <= loadErr_d;
      end
   end

   assign bus.count_bcd_o = countBcd;
   assign bus.count_bin_o = countBin_q;
   assign bus.load_err_o  = loadErr_q;

`ifdef BCD_CNT_SATURATE_EN
   assign bus.carry_o  = 1'b0;
   assign bus.borrow_o = 1'b0;
`else
   assign bus.carry_o  = ~rst_i & (stepOp == STEP_UP) & atMax;
   assign bus.borrow_o = ~rst_i & (stepOp == STEP_DOWN) & atZero;
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised self-checking bench for bcd_updown_counter against a decimal model;
// also covers a 59->23 cascade. Honours BCD_CNT_SATURATE_EN when defined.
module tb_bcd_updown_counter;

   logic clk;
   logic rst;
   int   vecCount;
   int   missCount;
   int   modelCount;

   bcd_updown_counter_if #(.DIGITS(2), .MAX_COUNT(59)) dutIf ();
   bcd_updown_counter_if #(.DIGITS(2), .MAX_COUNT(59)) minIf ();
   bcd_updown_counter_if #(.DIGITS(2), .MAX_COUNT(23)) hrIf ();

   bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(59)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (dutIf)
   );

   bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(59)) minDut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (minIf)
   );

   bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(23)) hrDut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (hrIf)
   );

   assign hrIf.inc_i = minIf.carry_o;
   assign hrIf.dec_i = minIf.borrow_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: plain decimal arithmetic on an integer count.
   function automatic logic [7:0] toBcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   function automatic int decodeLoad(input logic [7:0] v, input int maxC, output bit ok);
      int hi;
      int lo;
      hi = int'(v[7:4]);
      lo = int'(v[3:0]);
      ok = (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= maxC);
      return hi * 10 + lo;
   endfunction

   function automatic int modelNext(input int maxC, input int cnt, input bit clr, input bit ld,
                                    input logic [7:0] ldBcd, input bit inc, input bit dec);
      int v;
      bit ok;
      if (clr) return 0;
      if (ld) begin
         v = decodeLoad(ldBcd, maxC, ok);
         return ok ? v : cnt;
      end
      if (inc && !dec) begin
         if (cnt < maxC) return cnt + 1;
`ifdef BCD_CNT_SATURATE_EN
         return cnt;
`else
         return 0;
`endif
      end
      if (dec && !inc) begin
         if (cnt > 0) return cnt - 1;
`ifdef BCD_CNT_SATURATE_EN
         return cnt;
`else
         return maxC;
`endif
      end
      return cnt;
   endfunction

   function automatic bit modelCarry(input int maxC, input int cnt, input bit clr, input bit ld,
                                     input bit inc, input bit dec);
`ifdef BCD_CNT_SATURATE_EN
      return 1'b0;
`else
      return inc && !dec && !clr && !ld && (cnt == maxC);
`endif
   endfunction

   function automatic bit modelBorrow(input int cnt, input bit clr, input bit ld,
                                      input bit inc, input bit dec);
`ifdef BCD_CNT_SATURATE_EN
      return 1'b0;
`else
      return dec && !inc && !clr && !ld && (cnt == 0);
`endif
   endfunction

   function automatic bit modelErr(input int maxC, input bit clr, input bit ld, input logic [7:0] ldBcd);
      bit ok;
      int v;
      v = decodeLoad(ldBcd, maxC, ok);
      return ld && !clr && !ok && (v >= 0);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge; checks the cascade pulses mid-cycle, then the registered result.
   task automatic applyStimulus(input string tag, input bit clr, input bit ld, input logic [7:0] ldBcd,
                                input bit inc, input bit dec);
      int  expCount;
      bit  expErr;
      dutIf.clear_i    = clr;
      dutIf.load_i     = ld;
      dutIf.load_bcd_i = ldBcd;
      dutIf.inc_i      = inc;
      dutIf.dec_i      = dec;
      #2;
      checkOutput({tag, ".carry"}, 32'(dutIf.carry_o), 32'(modelCarry(59, modelCount, clr, ld, inc, dec)));
      checkOutput({tag, ".borrow"}, 32'(dutIf.borrow_o), 32'(modelBorrow(modelCount, clr, ld, inc, dec)));
      expCount = modelNext(59, modelCount, clr, ld, ldBcd, inc, dec);
      expErr   = modelErr(59, clr, ld, ldBcd);
      @(posedge clk);
      #1;
      modelCount = expCount;
      checkOutput({tag, ".bcd"}, 32'(dutIf.count_bcd_o), 32'(toBcd(modelCount)));
      checkOutput({tag, ".bin"}, 32'(dutIf.count_bin_o), 32'(modelCount));
      checkOutput({tag, ".err"}, 32'(dutIf.load_err_o), 32'(expErr));
      dutIf.clear_i = 1'b0;
      dutIf.load_i  = 1'b0;
      dutIf.inc_i   = 1'b0;
      dutIf.dec_i   = 1'b0;
   endtask

   initial begin
      int minCount;
      int hrCount;
      int expMin;
      int expHr;
      bit expCarry;
      vecCount   = 0;
      missCount  = 0;
      modelCount = 0;

      rst = 1'b1;
      dutIf.clear_i = 1'b0; dutIf.load_i = 1'b0; dutIf.load_bcd_i = '0;
      dutIf.inc_i = 1'b0;   dutIf.dec_i = 1'b1;
      minIf.clear_i = 1'b0; minIf.load_i = 1'b0; minIf.load_bcd_i = '0;
      minIf.inc_i = 1'b0;   minIf.dec_i = 1'b0;
      hrIf.clear_i = 1'b0;  hrIf.load_i = 1'b0;  hrIf.load_bcd_i = '0;

      #3;
      checkOutput("reset.bcd", 32'(dutIf.count_bcd_o), 32'h0);
      checkOutput("reset.bin", 32'(dutIf.count_bin_o), 32'h0);
      checkOutput("reset.err", 32'(dutIf.load_err_o), 32'h0);
      checkOutput("reset.borrow", 32'(dutIf.borrow_o), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      dutIf.dec_i = 1'b0;

      $display("[TB] counting up through the full range");
      for (int i = 0; i < 60; i++) begin
         applyStimulus($sformatf("inc%0d", i), 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end

      applyStimulus("decFromZero", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      applyStimulus("load47", 1'b0, 1'b1, 8'h47, 1'b0, 1'b0);
      applyStimulus("load4A", 1'b0, 1'b1, 8'h4A, 1'b0, 1'b0);
      applyStimulus("afterBadDigit", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus("load63", 1'b0, 1'b1, 8'h63, 1'b1, 1'b0);
      applyStimulus("afterOverRange", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      applyStimulus("load59", 1'b0, 1'b1, 8'h59, 1'b0, 1'b0);
      applyStimulus("incDecAt59", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      applyStimulus("clearIncAt59", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus("loadWithDec", 1'b0, 1'b1, 8'h12, 1'b0, 1'b1);
      applyStimulus("decAtZeroSat", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus("decAtZero", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      $display("[TB] randomised traffic");
      for (int i = 0; i < 300; i++) begin
         int r;
         bit clr;
         bit ld;
         logic [7:0] ldBcd;
         r     = int'($urandom_range(0, 15));
         clr   = (r == 0);
         ld    = (r == 1) || (r == 2);
         ldBcd = ($urandom_range(0, 1) == 1) ? toBcd(int'($urandom_range(0, 59)))
                                             : 8'($urandom_range(0, 255));
         applyStimulus($sformatf("rnd%0d", i), clr, ld, ldBcd,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] cascade 59 into 23");
      minIf.load_i = 1'b1; minIf.load_bcd_i = 8'h59;
      hrIf.load_i  = 1'b1; hrIf.load_bcd_i  = 8'h23;
      @(posedge clk);
      #1;
      minIf.load_i = 1'b0;
      hrIf.load_i  = 1'b0;
      minCount = 59;
      hrCount  = 23;
      checkOutput("cascade.minLoad", 32'(minIf.count_bcd_o), 32'(toBcd(minCount)));
      checkOutput("cascade.hrLoad", 32'(hrIf.count_bcd_o), 32'(toBcd(hrCount)));
      minIf.inc_i = 1'b1;
      #2;
      expCarry = modelCarry(59, minCount, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("cascade.carry", 32'(minIf.carry_o), 32'(expCarry));
      expMin = modelNext(59, minCount, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      expHr  = modelNext(23, hrCount, 1'b0, 1'b0, 8'h00, expCarry, 1'b0);
      @(posedge clk);
      #1;
      minIf.inc_i = 1'b0;
      checkOutput("cascade.min", 32'(minIf.count_bcd_o), 32'(toBcd(expMin)));
      checkOutput("cascade.hr", 32'(hrIf.count_bcd_o), 32'(toBcd(expHr)));
      checkOutput("cascade.hrBin", 32'(hrIf.count_bin_o), 32'(expHr));

      $display("[TB] asynchronous reset mid-cycle");
      applyStimulus("load31", 1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
      dutIf.inc_i = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      checkOutput("asyncRst.bcd", 32'(dutIf.count_bcd_o), 32'h0);
      checkOutput("asyncRst.bin", 32'(dutIf.count_bin_o), 32'h0);
      checkOutput("asyncRst.carry", 32'(dutIf.carry_o), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      dutIf.inc_i = 1'b0;
      modelCount = 0;
      applyStimulus("postRstInc", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
